// File: rtl/boot_step_ctrl.sv
// Boot/step controller: loads a program into a 16x8 RAM, then runs, halts or
// single-steps the CPU by driving its ring-counter enable and clear.
module boot_step_ctrl (
  input  logic       clk,
  input  logic       clr,
  input  logic       load_start,
  input  logic [3:0] load_last,
  input  logic [7:0] din,
  input  logic       din_valid,
  output logic       din_ready,
  input  logic       run,
  input  logic       halt,
  input  logic       step,
  output logic       ram_sel,
  output logic [3:0] ram_addr,
  output logic [7:0] ram_din,
  output logic       ram_we_ld,
  output logic       cpu_ce,
  output logic       cpu_clr,
  output logic       loaded,
  output logic [2:0] state
);

  localparam int unsigned AW = 4;
  localparam int unsigned SW = 3;
  localparam int unsigned CW = 2;

  typedef enum logic [SW-1:0] {
    S_IDLE = 3'd0,
    S_LOAD = 3'd1,
    S_RUN  = 3'd2,
    S_HALT = 3'd3,
    S_STEP = 3'd4
  } state_t;

  state_t        r_state;
  logic [AW-1:0] r_addr;
  logic [CW-1:0] r_step_cnt;
  logic          r_loaded;

  logic          w_load_done;

  // Final byte of a load: the requested last address, or the top of RAM.
  assign w_load_done = (r_addr == load_last) || (r_addr == '1);

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      r_state    <= S_IDLE;
      r_addr     <= '0;
      r_step_cnt <= '0;
      r_loaded   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (load_start) begin
            r_state  <= S_LOAD;
            r_addr   <= '0;
            r_loaded <= 1'b0;
          end else if (!halt && run && r_loaded) begin
            r_state <= S_RUN;
          end
        end
        S_LOAD: begin
          if (load_start) begin
            r_addr   <= '0;
            r_loaded <= 1'b0;
          end else if (din_valid) begin
            if (r_addr != '1) begin
              r_addr <= r_addr + AW'(1);
            end
            if (w_load_done) begin
              r_state  <= S_IDLE;
              r_loaded <= 1'b1;
            end
          end
        end
        S_RUN: begin
          if (load_start) begin
            r_state  <= S_LOAD;
            r_addr   <= '0;
            r_loaded <= 1'b0;
          end else if (halt) begin
            r_state <= S_HALT;
          end
        end
        S_HALT: begin
          if (load_start) begin
            r_state  <= S_LOAD;
            r_addr   <= '0;
            r_loaded <= 1'b0;
          end else if (!halt && run) begin
            r_state <= S_RUN;
          end else if (!halt && step) begin
            r_state    <= S_STEP;
            r_step_cnt <= '0;
          end
        end
        S_STEP: begin
          if (load_start) begin
            r_state    <= S_LOAD;
            r_addr     <= '0;
            r_loaded   <= 1'b0;
            r_step_cnt <= '0;
          end else begin
            // One instruction is four ring-counter cycles.
            r_step_cnt <= r_step_cnt + CW'(1);
            if (r_step_cnt == '1) begin
              r_state <= S_HALT;
            end
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // CPU-side controls decoded from the registered state.
  always_comb begin
    ram_sel = 1'b1;
    cpu_clr = 1'b1;
    cpu_ce  = 1'b0;
    case (r_state)
      S_RUN, S_STEP: begin
        ram_sel = 1'b0;
        cpu_clr = 1'b0;
        cpu_ce  = 1'b1;
      end
      S_HALT: begin
        ram_sel = 1'b0;
        cpu_clr = 1'b0;
      end
      default: begin
      end
    endcase
  end

  assign din_ready = (r_state == S_LOAD);
  assign ram_we_ld = din_ready && din_valid;
  assign ram_addr  = r_addr;
  assign ram_din   = din;
  assign loaded    = r_loaded;
  assign state     = r_state;

endmodule

// File: doc/boot_step_ctrl.md
BOOT_STEP_CTRL -- requirements
Module: boot_step_ctrl

Interface
REQ-001 SHALL expose: clk  in  1  single system clock; all state changes on rising edge.
REQ-002 SHALL expose: clr  in  1  asynchronous, active-high reset.
REQ-003 SHALL expose: load_start  in  1  request to enter program-load mode.
REQ-004 SHALL expose: load_last  in  4  last RAM address to be written during a load.
REQ-005 SHALL expose: din  in  8  program byte.
REQ-006 SHALL expose: din_valid  in  1  program byte present.
REQ-007 SHALL expose: din_ready  out  1  loader accepts a byte this cycle.
REQ-008 SHALL expose: run, halt, step  in  1 each  CPU run, stop and single-instruction requests.
REQ-009 SHALL expose: ram_sel  out  1  1 = loader owns the RAM port, 0 = CPU owns it.
REQ-010 SHALL expose: ram_addr  out  4  loader write address.
REQ-011 SHALL expose: ram_din  out  8  loader write data.
REQ-012 SHALL expose: ram_we_ld  out  1  loader RAM write strobe.
REQ-013 SHALL expose: cpu_ce  out  1  drives the control-unit ring counter enable (ce).
REQ-014 SHALL expose: cpu_clr  out  1  drives the control-unit clear (clr).
REQ-015 SHALL expose: loaded  out  1  a complete program has been written.
REQ-016 SHALL expose: state  out  3  current FSM state code, for debug.

Function
REQ-017 SHALL implement states: IDLE=0, LOAD=1, RUN=2, HALT=3, STEP=4; other codes SHALL return to IDLE on the next edge.
REQ-018 Command priority when several are sampled together SHALL be load_start > halt > run > step.
REQ-019 IDLE: ram_sel=1, cpu_clr=1, cpu_ce=0, din_ready=0.
- load_start -> LOAD, with the address counter set to 0 and loaded cleared.
- run with loaded=1 -> RUN.
- run with loaded=0, and step in any case -> ignored.
REQ-020 LOAD: ram_sel=1, cpu_clr=1, cpu_ce=0, din_ready=1.
- Each cycle with din_valid=1: ram_we_ld=1 combinationally that same cycle, ram_din=din, ram_addr=counter; the counter increments at the edge.
REQ-021 LOAD SHALL exit to IDLE, setting loaded=1, on the edge that accepts the byte at address load_last.
- load_last=0 SHALL load exactly one byte.
- The counter SHALL never wrap: address 15 is always the final write.
REQ-022 LOAD with din_valid=0 SHALL stall indefinitely: no write, counter held.
- load_start while in LOAD SHALL restart at address 0.
REQ-023 RUN: ram_sel=0, cpu_clr=0, cpu_ce=1, din_ready=0, ram_we_ld=0.
- halt -> HALT; cpu_ce SHALL drop the cycle after halt is sampled.
- load_start -> LOAD; cpu_clr SHALL reassert and ram_sel=1 on the next cycle.
REQ-024 HALT: ram_sel=0, cpu_clr=0, cpu_ce=0; CPU state frozen.
- run -> RUN.
- step -> STEP.
- load_start -> LOAD.
REQ-025 STEP SHALL assert cpu_ce for exactly 4 consecutive cycles (one fetch/decode/execute/increment instruction) using a 2-bit step counter, then return to HALT.
- halt, run and step received during STEP SHALL be ignored.
- load_start SHALL abort to LOAD.
REQ-026 All outputs SHALL be decoded from registered state only, except ram_we_ld, ram_addr, ram_din and din_ready, which are state-gated combinational.
REQ-027 ram_addr SHALL hold the counter value and ram_din SHALL pass din in all states; writes are qualified solely by ram_we_ld.

Reset
REQ-028 clr=1 SHALL immediately, without waiting for a clock, force:
- state=IDLE, address counter=0, step counter=0, loaded=0;
- ram_sel=1, cpu_clr=1, cpu_ce=0, din_ready=0, ram_we_ld=0.
REQ-029 clr asserted during LOAD, RUN or STEP SHALL abort the operation; no write SHALL occur in the reset cycle, and loaded SHALL read 0 afterwards.

Verification
REQ-030 Load: load_last=2, bytes 0xA1,0xB2,0xC3 with din_valid held high.
- Required: writes to addresses 0,1,2 on consecutive cycles.
- Required: loaded=1 and state=IDLE on the edge after the third byte.
REQ-031 Load stall: din_valid toggled 1,0,0,1 with load_last=1.
- Required: exactly two writes, to addresses 0 and 1.
- Required: counter held during the gaps.
REQ-032 Run/halt: run from IDLE with loaded=1, then halt 10 cycles later.
- Required: cpu_clr=0 and cpu_ce=1 for exactly 10 cycles.
- Required: state=HALT afterwards, ram_sel=0.
REQ-033 Step: step from HALT, with step pulsed again 2 cycles later.
- Required: cpu_ce high exactly 4 cycles, then state=HALT; the second step is ignored.
REQ-034 Precedence: load_start, halt and run asserted together in RUN.
- Required: state=LOAD next cycle, cpu_clr=1, counter=0, loaded=0.
REQ-035 Reset mid-load: clr asserted asynchronously between edges after one byte of a 4-byte load.
- Required: outputs reach their reset values before the next edge.
- Required: loaded=0, and run from IDLE is then ignored.
